// File: rtl/aes_pkg.sv
// Shared AES-128 constants and types for the key-schedule blocks.
// Holds the forward S-box, the round-constant table and the scheduler state encoding.
package aes_pkg;

  typedef logic [31:0]  word_t;
  typedef logic [127:0] key_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    EMIT = 2'd2
  } ksched_state_t;

  localparam logic [0:255][7:0] SBOX = {
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [1:10][7:0] RCON = {
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // Round constant lookup; indices outside 1..10 contribute nothing.
  function automatic logic [7:0] rcon_of(input logic [3:0] rnd);
    logic [7:0] rc;
    if ((rnd >= 4'd1) && (rnd <= 4'd10)) begin
      rc = RCON[rnd];
    end else begin
      rc = 8'h00;
    end
    return rc;
  endfunction

endpackage

// File: rtl/aes_g_word.sv
// Key-expansion G function: SubWord(RotWord(w)) with the round constant folded into the top byte.
module aes_g_word
  import aes_pkg::*;
(
  input  word_t      w,
  input  logic [3:0] rnd,
  output word_t      g
);

  word_t rot_s;

  // Rotate left by one byte, substitute each byte, then add Rcon to the leading byte.
  always_comb begin
    rot_s = {w[23:0], w[31:24]};
    g     = {SBOX[rot_s[31:24]] ^ rcon_of(rnd),
             SBOX[rot_s[23:16]],
             SBOX[rot_s[15:8]],
             SBOX[rot_s[7:0]]};
  end

endmodule

// File: rtl/inv_key_sched.sv
// Sequential AES-128 decryption key scheduler: expands forward to round 10, then
// walks the schedule backwards, presenting round keys 10..0 over a valid/ready handshake.
module inv_key_sched
  import aes_pkg::*;
#(
  parameter int unsigned NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic         key_ready,
  output logic         key_valid,
  output logic [127:0] key_out,
  output logic [3:0]   round_out,
  output logic         busy,
  output logic         done
);

  localparam logic [3:0] LAST_RND = 4'(NR);

  ksched_state_t state_r;
  key_t          key_r;
  logic [3:0]    rnd_r;

  word_t w3p_s;
  word_t g_in_s;
  word_t g_s;
  key_t  fwd_s;
  key_t  inv_s;

  function automatic key_t fwd(input key_t k, input word_t g);
    word_t w0, w1, w2, w3;
    w0 = k[127:96] ^ g;
    w1 = k[95:64]  ^ w0;
    w2 = k[63:32]  ^ w1;
    w3 = k[31:0]   ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // g must already be G(W3 ^ W2, rnd) of the key being rolled back.
  function automatic key_t inv(input key_t k, input word_t g);
    word_t w0p, w1p, w2p, w3p;
    w3p = k[31:0]   ^ k[63:32];
    w2p = k[63:32]  ^ k[95:64];
    w1p = k[95:64]  ^ k[127:96];
    w0p = k[127:96] ^ g;
    return {w0p, w1p, w2p, w3p};
  endfunction

  assign w3p_s = key_r[31:0] ^ key_r[63:32];

  // Single G instance: forward steps feed W3, backward steps feed the recovered W3.
  always_comb begin
    if (state_r == EMIT) begin
      g_in_s = w3p_s;
    end else begin
      g_in_s = key_r[31:0];
    end
    fwd_s = fwd(key_r, g_s);
    inv_s = inv(key_r, g_s);
  end

  aes_g_word u_g_word (
    .w   (g_in_s),
    .rnd (rnd_r),
    .g   (g_s)
  );

  // Scheduler FSM with registered handshake and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      key_r     <= 128'h0;
      rnd_r     <= 4'd0;
      key_valid <= 1'b0;
      key_out   <= 128'h0;
      round_out <= 4'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            key_r   <= key_in;
            rnd_r   <= 4'd1;
            state_r <= FWD;
            busy    <= 1'b1;
          end else begin
            busy <= 1'b0;
          end
        end
        FWD: begin
          key_r <= fwd_s;
          if (rnd_r == LAST_RND) begin
            state_r   <= EMIT;
            rnd_r     <= LAST_RND;
            key_valid <= 1'b1;
            key_out   <= fwd_s;
            round_out <= LAST_RND;
          end else begin
            rnd_r <= rnd_r + 4'd1;
          end
        end
        EMIT: begin
          if (key_ready) begin
            if (rnd_r != 4'd0) begin
              key_r     <= inv_s;
              key_out   <= inv_s;
              rnd_r     <= rnd_r - 4'd1;
              round_out <= rnd_r - 4'd1;
            end else begin
              state_r   <= IDLE;
              key_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
            end
          end else begin
            key_r <= key_r;
          end
        end
        default: begin
          state_r   <= IDLE;
          key_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inv_key_sched.sv
// Self-checking bench for inv_key_sched; expected round keys come from a plain
// FIPS-197 forward expansion whose S-box is derived from GF(2^8) arithmetic.
module tb_inv_key_sched;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] key_in;
  logic         key_ready;
  logic         key_valid;
  logic [127:0] key_out;
  logic [3:0]   round_out;
  logic         busy;
  logic         done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]   sbox_m [0:255];
  logic [7:0]   rcon_m [1:10];
  logic [127:0] exp_rk [0:10];

  always #5 clk = ~clk;

  inv_key_sched #(.NR(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .key_in    (key_in),
    .key_ready (key_ready),
    .key_valid (key_valid),
    .key_out   (key_out),
    .round_out (round_out),
    .busy      (busy),
    .done      (done)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  task automatic build_tables();
    logic [7:0] inv, s, r, rc;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      s = inv; r = inv;
      for (int k = 0; k < 4; k++) begin
        r = {r[6:0], r[7]};
        s = s ^ r;
      end
      sbox_m[a] = s ^ 8'h63;
    end
    rc = 8'h01;
    for (int j = 1; j <= 10; j++) begin
      rcon_m[j] = rc;
      rc = gmul(rc, 8'h02);
    end
  endtask

  task automatic expand(input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]};
        t = t ^ {rcon_m[i/4], 24'h0};
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; key_ready = 1'b0; key_in = {$urandom, $urandom, $urandom, $urandom};
    repeat (3) @(negedge clk);
    n_checks++;
    if ({key_valid, key_out, round_out, busy, done} !== 135'h0) begin
      n_fail++;
      $display("FAIL reset: valid=%b key=%h round=%0d busy=%b done=%b, required all zero",
               key_valid, key_out, round_out, busy, done);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Runs one schedule with key_ready high; checks latency, every key, FIPS vectors and done timing.
  task automatic test_known(input string nm, input logic [127:0] k,
                            input logic [127:0] r10, input logic [127:0] r1);
    int cyc;
    expand(k);
    key_ready = 1'b1; key_in = k; start = 1'b1;
    @(negedge clk); start = 1'b0; cyc = 1;
    while (!key_valid && cyc < 50) begin @(negedge clk); cyc++; end
    n_checks++;
    if (cyc !== 11) begin n_fail++; $display("FAIL %s_latency: cycle %0d, required 11", nm, cyc); end
    for (int r = 10; r >= 0; r--) begin
      n_checks++;
      if (key_valid !== 1'b1 || round_out !== 4'(r) || key_out !== exp_rk[r] || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL %s_round%0d: valid=%b busy=%b round=%0d key=%h, required 1 1 %0d %h",
                 nm, r, key_valid, busy, round_out, key_out, r, exp_rk[r]);
      end
      if (r == 10 || r == 1 || r == 0) begin
        n_checks++;
        if (key_out !== (r == 10 ? r10 : (r == 1 ? r1 : k))) begin
          n_fail++;
          $display("FAIL %s_vector%0d: key=%h", nm, r, key_out);
        end
      end
      @(negedge clk); cyc++;
    end
    n_checks++;
    if (done !== 1'b1 || key_valid !== 1'b0 || busy !== 1'b0 || cyc !== 22) begin
      n_fail++;
      $display("FAIL %s_done: done=%b valid=%b busy=%b cycle=%0d, required 1 0 0 22",
               nm, done, key_valid, busy, cyc);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || key_out !== k || round_out !== 4'd0) begin
      n_fail++;
      $display("FAIL %s_after_done: done=%b key=%h round=%0d, required 0 %h 0", nm, done, key_out, round_out, k);
    end
  endtask

  // Random keys with random key_ready, optional stray start pulses and a fixed stall at round 7.
  task automatic run_sched(input string nm, input logic [127:0] k, input bit rand_ready,
                           input bit stray_start, input bit stall7);
    int exp_r, cyc, stall;
    bit seen, fin;
    expand(k);
    key_in = k; start = 1'b1; key_ready = 1'b1;
    exp_r = 10; cyc = 0; seen = 1'b0; fin = 1'b0; stall = 0;
    while (!fin && cyc < 300) begin
      @(negedge clk); cyc++;
      start = 1'b0;
      if (exp_r < 0) begin
        n_checks++;
        if (done !== 1'b1 || key_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL %s_done: done=%b valid=%b, required 1 0", nm, done, key_valid);
        end
        fin = 1'b1;
      end else if (key_valid) begin
        seen = 1'b1;
        n_checks++;
        if (round_out !== 4'(exp_r) || key_out !== exp_rk[exp_r]) begin
          n_fail++;
          $display("FAIL %s_round: round=%0d key=%h, required %0d %h", nm, round_out, key_out, exp_r, exp_rk[exp_r]);
        end
      end else if (seen) begin
        n_checks++; n_fail++;
        $display("FAIL %s_valid_drop: valid=0 at round %0d, required 1", nm, exp_r);
      end
      if (stray_start && (cyc == 5 || (key_valid && round_out == 4'd5))) begin
        start = 1'b1; key_in = ~k ^ {$urandom, $urandom, $urandom, $urandom};
      end
      if (stall7 && key_valid && round_out == 4'd7 && stall < 5) begin
        key_ready = 1'b0; stall++;
      end else begin
        key_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (key_valid && key_ready && exp_r >= 0) exp_r--;
    end
    start = 1'b0;
    n_checks++;
    if (!fin || (stall7 && stall != 5)) begin
      n_fail++; $display("FAIL %s_timeout: finished=%b stalls=%0d", nm, fin, stall);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 4; i++)
      run_sched("random", {$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure();
    run_sched("stall7", {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_start_ignored();
    run_sched("stray_start", {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_reset_midway();
    int cyc;
    key_in = {$urandom, $urandom, $urandom, $urandom}; key_ready = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0; cyc = 0;
    while (!(key_valid && round_out == 4'd4) && cyc < 50) begin @(negedge clk); cyc++; end
    n_checks++;
    if (cyc >= 50) begin n_fail++; $display("FAIL midreset_reach4: round 4 never valid"); end
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({key_valid, key_out, round_out, busy, done} !== 135'h0) begin
      n_fail++;
      $display("FAIL midreset_outputs: valid=%b key=%h round=%0d busy=%b done=%b, required all zero",
               key_valid, key_out, round_out, busy, done);
    end
    rst = 1'b0;
    run_sched("after_reset", {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [127:0] k2;
    int cyc;
    k2 = {$urandom, $urandom, $urandom, $urandom};
    key_in = {$urandom, $urandom, $urandom, $urandom}; key_ready = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0; cyc = 0;
    while (!done && cyc < 50) begin @(negedge clk); cyc++; end
    n_checks++;
    if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_first_done: done=%b, required 1", done); end
    expand(k2);
    key_in = k2; start = 1'b1;
    @(negedge clk); start = 1'b0; cyc = 1;
    while (!key_valid && cyc < 50) begin @(negedge clk); cyc++; end
    n_checks++;
    if (cyc !== 11 || round_out !== 4'd10 || key_out !== exp_rk[10]) begin
      n_fail++;
      $display("FAIL b2b_second: cycle=%0d round=%0d key=%h, required 11 10 %h", cyc, round_out, key_out, exp_rk[10]);
    end
    while (!done && cyc < 80) begin @(negedge clk); cyc++; end
    n_checks++;
    if (cyc !== 22 || key_out !== k2) begin
      n_fail++; $display("FAIL b2b_second_done: cycle=%0d key=%h, required 22 %h", cyc, key_out, k2);
    end
    @(negedge clk);
  endtask

  initial begin
    build_tables();
    test_reset();
    test_known("fips", 128'h2b7e151628aed2a6abf7158809cf4f3c,
               128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 128'ha0fafe1788542cb123a339392a6c7605);
    test_known("zero", 128'h0,
               128'hb4ef5bcb3e92e21123e951cf6f8f188e, 128'h62636363626363636263636362636363);
    test_random();
    test_backpressure();
    test_start_ignored();
    test_reset_midway();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/inv_key_sched.md
# inv_key_sched

- Sequential AES-128 decryption key scheduler.
- Takes the cipher key, runs the forward expansion to round key 10, then emits round keys 10, 9, …, 0 one at a time over a valid/ready handshake, using the inverse key-expansion recurrence.
- Feeds the inverse-cipher datapath: it is the read-back counterpart of the per-round forward key generator.

## Interface
Parameters:
- NR, 10, number of AES rounds (AES-128 only; other values unsupported)

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  begin a schedule; sampled only in IDLE
- key_in  in  128  cipher key, sampled on the start cycle; word 0 = key_in[127:96]
- key_ready  in  1  consumer accepts key_out this cycle
- key_valid  out  1  key_out/round_out hold a valid round key
- key_out  out  128  current round key, same word order as key_in
- round_out  out  4  round index of key_out (10 down to 0)
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse after round 0 is accepted

## Operation
- Reset values: key_valid=0, key_out=0, round_out=0, busy=0, done=0, state=IDLE.
- States: IDLE, FWD, EMIT.
- IDLE -> FWD on start. Latch key_in into key_reg; set rnd=1.
- FWD: each cycle key_reg <= fwd(key_reg, rnd); rnd++.
  - fwd computes W0'=W0^G(W3,rnd), W1'=W1^W0', W2'=W2^W1', W3'=W3^W2'.
  - G = SubWord(RotWord(w)) ^ {Rcon[rnd],24'h0}; Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.
  - After the rnd=10 update: state -> EMIT, rnd=10.
- EMIT: key_valid=1, key_out=key_reg, round_out=rnd.
  - On key_valid&key_ready with rnd>0: key_reg <= inv(key_reg, rnd); rnd--.
  - inv computes W3p=W3^W2, W2p=W2^W1, W1p=W1^W0, W0p=W0^G(W3p,rnd).
  - On accept with rnd==0: state -> IDLE, key_valid->0, done=1 for one cycle. key_out/round_out hold their last values.
- start outside IDLE is ignored; key_in is not re-sampled.
- key_out and round_out are stable while key_valid&!key_ready. key_valid never drops without an accept.
- rst in any state returns to IDLE with reset values on the next edge. A partially emitted schedule is discarded.
- All XOR is 128-bit bitwise. No carries, no width growth.

## Timing
- start sampled at edge E0.
- FWD occupies edges E1..E10.
- key_valid first high after E10 (the 11th cycle after the start cycle), with round_out=10.
- With key_ready held high: one key per cycle. Rounds 10..0 take 11 cycles. done pulses the cycle after round 0 is accepted. Total start-to-done = 22 cycles.
- Back-to-back: start in the done cycle is accepted, since the state is already IDLE.
- Combinational path per cycle: one G (four S-box lookups) plus a four-word XOR chain. All outputs are registered.

## Structure
- Shared package aes_pkg:
  - 256-entry S-box constant
  - Rcon table, indexed 1..10
  - typedef word_t (32-bit)
  - typedef key_t (128-bit)
  - enum ksched_state_t {IDLE, FWD, EMIT}
- One sub-module, aes_g_word: input word_t w and 4-bit rnd, output word_t g.
  - Instantiated once and muxed between W3 (FWD) and W3p (EMIT).
- fwd/inv are combinational functions inside inv_key_sched.

## Test plan
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, start, key_ready=1:
  - first output round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6 at cycle 11
  - round 1 = a0fafe1788542cb123a339392a6c7605
  - round 0 = 2b7e151628aed2a6abf7158809cf4f3c
  - done at cycle 22
- All-zero key: round 10 = b4ef5bcb3e92e21123e951cf6f8f188e; round 1 = 62636363626363636263636362636363; round 0 = 0.
- Backpressure: key_ready low for 5 cycles at round 7. key_out and round_out stay constant and key_valid stays 1. The sequence resumes unchanged.
- start pulsed during FWD and during EMIT with a different key_in: no effect, and the output sequence matches the original key.
- rst asserted while round_out=4 is valid: next cycle all outputs are at reset values and busy=0. A new start then yields the full 10..0 sequence.
- start asserted in the done cycle: second schedule begins immediately, key_valid high 11 cycles later.
